mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register: takes the EX/MEM outputs, runs the data-memory access over a req/ack handshake, and selects the writeback value.
- Freezes the front of the pipeline (stall) while an access is outstanding.
- Contains the MEM/WB pipeline register, so it delivers registered writeback signals to the WB stage and register file.

Parameters:
- DATA_W, 32, data/ALU/PC width
- TIMEOUT, 16, max wait cycles for mem_ack (used only with MEM_TIMEOUT_EN); legal range 2..255

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high reset
- EX_MEM_PCP4_in  in  DATA_W  PC+4 from EX/MEM
- ALUResult_in  in  DATA_W  ALU result, also memory byte address
- BusB_in  in  DATA_W  store data
- MemWr_in  in  1  store request
- MemRd_in  in  1  load request
- MemtoReg_in  in  2  writeback select
- RegWr_in  in  1  register write enable
- WrReg_in  in  5  destination register number
- mem_req  out  1  memory request (combinational)
- mem_we  out  1  1 = write
- mem_addr  out  DATA_W  = ALUResult_in
- mem_wdata  out  DATA_W  = BusB_in
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  access complete
- stall  out  1  hold PC/IF-ID/ID-EX/EX-MEM this cycle
- MEM_WB_data_out  out  DATA_W  writeback value
- MEM_WB_WrReg_out  out  5  destination register
- MEM_WB_RegWr_out  out  1  register write enable
- MEM_WB_err_out  out  1  access error flag

Behaviour:
- Reset: synchronous active-high on clk, clock and reset named clk/reset. Reset values:
  - all MEM_WB_* outputs = 0
  - state = IDLE, wait counter = 0
  - mem_req is forced to 0 in any cycle where reset = 1
- Access definition:
  - access = MemRd_in | MemWr_in. If both are 1, treat as a write.
  - misaligned = access & (ALUResult_in[1:0] != 0)
- Request outputs:
  - mem_req = ~reset & access & ~misaligned, in both IDLE and WAIT.
  - mem_we = MemWr_in.
  - Address and write data pass straight through. The upstream stall keeps them stable.
- Stall: stall = mem_req & ~mem_ack.
  - Zero-wait memory (ack in the same cycle as req) causes no stall.
- FSM states:
  - IDLE: if mem_req & ~mem_ack, go to WAIT.
  - WAIT: if mem_ack, go to IDLE. The counter increments each WAIT cycle and clears on entering IDLE.
- mem_ack while mem_req = 0 is ignored.
- MEM/WB update (every posedge, reset excepted):
  - stall = 1: load a bubble (RegWr = 0, err = 0, data = 0, WrReg = 0).
  - misaligned: no request is issued. Load RegWr = 0, err = 1, WrReg = WrReg_in, data = ALUResult_in. Takes 1 cycle, no stall.
  - otherwise: load RegWr = RegWr_in, WrReg = WrReg_in, err = 0.
- Writeback data select:
  - MemtoReg 00: ALUResult_in
  - MemtoReg 01: mem_rdata for a completed load; 0 if no load completed
  - MemtoReg 10: EX_MEM_PCP4_in
  - MemtoReg 11: treated as 00
- Latency: one cycle from EX/MEM to MEM/WB when the access acks in the same cycle. With N wait cycles: N bubbles, then the result.
- Reset asserted mid-WAIT: return to IDLE on that edge, drop mem_req in the same cycle. The outstanding ack is ignored only if it arrives while mem_req = 0.

Optional Feature:
- Macro: MEM_TIMEOUT_EN
- Defined:
  - In WAIT, when the counter reaches TIMEOUT-1 with no ack, abort: go to IDLE.
  - Force mem_req = 0 and stall = 0 for that one cycle. Load MEM/WB with RegWr = 0, err = 1, WrReg = WrReg_in, data = 0.
  - Upstream advances past the faulted instruction.
- Not defined: no counter logic is present. WAIT holds indefinitely, and err is raised only for misalignment.

Decomposition:
- Package mem_stage_pkg holds:
  - MemtoReg encodings MTR_ALU = 2'b00, MTR_MEM = 2'b01, MTR_PC4 = 2'b10
  - FSM state type {IDLE, WAIT}
  - DATA_W default
- One sub-module: memwb_reg, the MEM/WB register with synchronous reset and a bubble-insert input. The FSM, mux and handshake stay in the top level.

Test Plan:
- Zero-wait load: MemRd = 1, addr 0x100, MemtoReg = 01, RegWr = 1, WrReg = 5, ack same cycle with rdata 0xDEADBEEF -> stall never asserts; next edge data = 0xDEADBEEF, reg 5, RegWr = 1.
- 3-wait store: MemWr = 1, addr 0x204, BusB = 0x12345678, ack after 3 cycles -> mem_we = 1, stall high for 3 cycles, 3 bubbles with RegWr = 0, then RegWr = RegWr_in (0), err = 0.
- Non-memory ops: MemtoReg = 10, PCP4 = 0x40 -> data 0x40. MemtoReg = 00, ALU = 7 -> data 7. mem_req stays 0 throughout.
- Misaligned load: addr 0x102 -> mem_req = 0, stall = 0, next edge err = 1, RegWr = 0.
- Reset during WAIT (1-cycle pulse on cycle 2 of the wait) -> mem_req = 0 in the reset cycle, all MEM_WB outputs 0, state IDLE; a late ack is ignored.
- MEM_TIMEOUT_EN with TIMEOUT = 4 and no ack -> stall for 4 cycles, then err = 1, RegWr = 0, stall drops. Without the macro, stall persists for 100+ cycles.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: writeback select codes, FSM state type and default width.
package mem_stage_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef enum logic {IDLE, WAIT} mem_state_e;

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register with synchronous reset; bubble_i loads an all-zero (no-op) entry.
module memwb_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              bubble_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [4:0]        wr_reg_i,
  input  logic              reg_wr_i,
  input  logic              err_i,
  output logic [DATA_W-1:0] data_o,
  output logic [4:0]        wr_reg_o,
  output logic              reg_wr_o,
  output logic              err_o
);

  logic [DATA_W-1:0] data_q;
  logic [4:0]        wr_reg_q;
  logic              reg_wr_q;
  logic              err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || bubble_i) begin
      data_q   <= '0;
      wr_reg_q <= '0;
      reg_wr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      data_q   <= data_i;
      wr_reg_q <= wr_reg_i;
      reg_wr_q <= reg_wr_i;
      err_q    <= err_i;
    end
  end

  assign data_o   = data_q;
  assign wr_reg_o = wr_reg_q;
  assign reg_wr_o = reg_wr_q;
  assign err_o    = err_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: data-memory req/ack handshake, front-end stall, writeback select and MEM/WB register.
// Define MEM_TIMEOUT_EN to abort accesses whose ack does not arrive within TIMEOUT cycles.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] EX_MEM_PCP4_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] BusB_in,
  input  logic              MemWr_in,
  input  logic              MemRd_in,
  input  logic [1:0]        MemtoReg_in,
  input  logic              RegWr_in,
  input  logic [4:0]        WrReg_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] MEM_WB_data_out,
  output logic [4:0]        MEM_WB_WrReg_out,
  output logic              MEM_WB_RegWr_out,
  output logic              MEM_WB_err_out
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_stage_ctrl: TIMEOUT must be in 2..255");
  end

  mem_state_e state_q, state_d;

  logic              access;
  logic              misaligned;
  logic              abort;
  logic              load_done;
  logic [DATA_W-1:0] wb_data;
  logic              wb_reg_wr;
  logic              wb_err;

  assign access     = MemRd_in | MemWr_in;
  assign misaligned = access & (ALUResult_in[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counter holds the index of the current WAIT cycle; abort fires on the last allowed one.
  assign abort = (state_q == WAIT) && (cnt_q == 8'(TIMEOUT - 1));
  assign cnt_d = ((state_q == WAIT) && (state_d == WAIT)) ? cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_req && !mem_ack) state_d = WAIT;
      WAIT:    if (mem_ack || !mem_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and MEM/WB next values
  always_comb begin
    mem_req   = ~reset & access & ~misaligned & ~abort;
    mem_we    = MemWr_in;
    mem_addr  = ALUResult_in;
    mem_wdata = BusB_in;
    stall     = mem_req & ~mem_ack;
    load_done = mem_req & mem_ack & MemRd_in & ~MemWr_in;

    case (MemtoReg_in)
      MTR_MEM: wb_data = load_done ? mem_rdata : '0;
      MTR_PC4: wb_data = EX_MEM_PCP4_in;
      default: wb_data = ALUResult_in;
    endcase
    wb_reg_wr = RegWr_in;
    wb_err    = 1'b0;

    if (misaligned) begin
      wb_reg_wr = 1'b0;
      wb_err    = 1'b1;
      wb_data   = ALUResult_in;
    end else if (abort) begin
      wb_reg_wr = 1'b0;
      wb_err    = 1'b1;
      wb_data   = '0;
    end
  end

  memwb_reg #(
    .DATA_W(DATA_W)
  ) u_memwb_reg (
    .clk_i    (clk),
    .reset_i  (reset),
    .bubble_i (stall),
    .data_i   (wb_data),
    .wr_reg_i (WrReg_in),
    .reg_wr_i (wb_reg_wr),
    .err_i    (wb_err),
    .data_o   (MEM_WB_data_out),
    .wr_reg_o (MEM_WB_WrReg_out),
    .reg_wr_o (MEM_WB_RegWr_out),
    .err_o    (MEM_WB_err_out)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: behavioural model compared every cycle plus directed literals.
module tb_mem_stage_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] EX_MEM_PCP4_in, ALUResult_in, BusB_in, mem_rdata;
  logic          MemWr_in, MemRd_in, RegWr_in, mem_ack;
  logic [1:0]    MemtoReg_in;
  logic [4:0]    WrReg_in;
  logic          mem_req, mem_we, stall;
  logic [DW-1:0] mem_addr, mem_wdata, MEM_WB_data_out;
  logic [4:0]    MEM_WB_WrReg_out;
  logic          MEM_WB_RegWr_out, MEM_WB_err_out;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .EX_MEM_PCP4_in   (EX_MEM_PCP4_in),
    .ALUResult_in     (ALUResult_in),
    .BusB_in          (BusB_in),
    .MemWr_in         (MemWr_in),
    .MemRd_in         (MemRd_in),
    .MemtoReg_in      (MemtoReg_in),
    .RegWr_in         (RegWr_in),
    .WrReg_in         (WrReg_in),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack),
    .stall            (stall),
    .MEM_WB_data_out  (MEM_WB_data_out),
    .MEM_WB_WrReg_out (MEM_WB_WrReg_out),
    .MEM_WB_RegWr_out (MEM_WB_RegWr_out),
    .MEM_WB_err_out   (MEM_WB_err_out)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Behavioural model: an access is aborted once it has been stalled TO cycles.
  int            m_stalled = 0;
  logic          m_acc, m_mis, m_abort, m_req, m_stall;
  logic [DW-1:0] m_data = '0;
  logic [4:0]    m_wrreg = '0;
  logic          m_regwr = 1'b0, m_err = 1'b0;

  always_comb begin
    m_acc   = MemRd_in || MemWr_in;
    m_mis   = m_acc && (ALUResult_in % 4 != 0);
    m_abort = ToEn && (m_stalled == TO);
    m_req   = !reset && m_acc && !m_mis && !m_abort;
    m_stall = m_req && !mem_ack;
  end

  function automatic logic [DW-1:0] select_wb();
    if (MemtoReg_in == 2'b01)
      return (m_req && mem_ack && MemRd_in && !MemWr_in) ? mem_rdata : '0;
    if (MemtoReg_in == 2'b10) return EX_MEM_PCP4_in;
    return ALUResult_in;
  endfunction

  always @(posedge clk) begin
    if (reset || m_stall) begin
      {m_data, m_wrreg, m_regwr, m_err} <= '0;
      m_stalled <= reset ? 0 : m_stalled + 1;
    end else begin
      m_stalled <= 0;
      m_wrreg   <= WrReg_in;
      if (m_mis) begin
        m_regwr <= 1'b0; m_err <= 1'b1; m_data <= ALUResult_in;
      end else if (m_abort) begin
        m_regwr <= 1'b0; m_err <= 1'b1; m_data <= '0;
      end else begin
        m_regwr <= RegWr_in; m_err <= 1'b0; m_data <= select_wb();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_req",   mem_req,          m_req);
      check("cmp_we",    mem_we,           MemWr_in);
      check("cmp_addr",  mem_addr,         ALUResult_in);
      check("cmp_wdata", mem_wdata,        BusB_in);
      check("cmp_stall", stall,            m_stall);
      check("cmp_data",  MEM_WB_data_out,  m_data);
      check("cmp_wrreg", MEM_WB_WrReg_out, m_wrreg);
      check("cmp_regwr", MEM_WB_RegWr_out, m_regwr);
      check("cmp_err",   MEM_WB_err_out,   m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] mtr, input logic rw,
                        input logic [4:0] wreg, input logic [DW-1:0] alu,
                        input logic [DW-1:0] busb, input logic [DW-1:0] pcp4);
    MemRd_in = rd; MemWr_in = wr; MemtoReg_in = mtr; RegWr_in = rw; WrReg_in = wreg;
    ALUResult_in = alu; BusB_in = busb; EX_MEM_PCP4_in = pcp4;
  endtask

  task automatic nop();
    set_op(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, '0, '0, '0);
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    // A pending load during reset must not raise mem_req.
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 5'd1, 32'h100, '0, '0);
    tick();
    @(negedge clk);
    check("rst_req", mem_req, 1'b0);
    tick();
    reset = 1'b0; nop(); chk_en = 1'b1;
    check("rst_data", MEM_WB_data_out, 0);
    check("rst_regwr", MEM_WB_RegWr_out, 0);
    check("rst_err", MEM_WB_err_out, 0);
    tick();

    // Zero-wait load
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 5'd5, 32'h100, '0, 32'h8);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("zw_stall", stall, 1'b0);
    check("zw_req", mem_req, 1'b1);
    tick();
    check("zw_data", MEM_WB_data_out, 32'hDEADBEEF);
    check("zw_model", m_data, 32'hDEADBEEF);
    check("zw_wrreg", MEM_WB_WrReg_out, 5);
    check("zw_regwr", MEM_WB_RegWr_out, 1);
    mem_ack = 1'b0; mem_rdata = '0;

    // Store with three wait cycles
    set_op(1'b0, 1'b1, 2'b00, 1'b0, 5'd9, 32'h204, 32'h12345678, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_stall", stall, 1'b1);
      check("st_we", mem_we, 1'b1);
      check("st_wdata", mem_wdata, 32'h12345678);
      tick();
      check("st_bubble", MEM_WB_RegWr_out, 0);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    check("st_ack_stall", stall, 1'b0);
    tick();
    check("st_regwr", MEM_WB_RegWr_out, 0);
    check("st_err", MEM_WB_err_out, 0);
    check("st_wrreg", MEM_WB_WrReg_out, 9);
    mem_ack = 1'b0;

    // Non-memory ops
    set_op(1'b0, 1'b0, 2'b10, 1'b1, 5'd2, 32'h3, '0, 32'h40);
    @(negedge clk);
    check("nm_req", mem_req, 1'b0);
    tick();
    check("nm_pc4", MEM_WB_data_out, 32'h40);
    set_op(1'b0, 1'b0, 2'b00, 1'b1, 5'd3, 32'h7, '0, 32'h44);
    tick();
    check("nm_alu", MEM_WB_data_out, 32'h7);
    set_op(1'b0, 1'b0, 2'b11, 1'b1, 5'd4, 32'h9, '0, 32'h48);
    tick();
    check("nm_mtr11", MEM_WB_data_out, 32'h9);

    // Misaligned load
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 5'd3, 32'h102, '0, '0);
    @(negedge clk);
    check("mis_req", mem_req, 1'b0);
    check("mis_stall", stall, 1'b0);
    tick();
    check("mis_err", MEM_WB_err_out, 1);
    check("mis_regwr", MEM_WB_RegWr_out, 0);
    check("mis_wrreg", MEM_WB_WrReg_out, 3);
    check("mis_data", MEM_WB_data_out, 32'h102);

    // Reset pulse on the second wait cycle, then a late ack with no access
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 5'd6, 32'h300, '0, '0);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rw_req", mem_req, 1'b0);
    check("rw_stall", stall, 1'b0);
    tick();
    reset = 1'b0;
    check("rw_data", MEM_WB_data_out, 0);
    check("rw_regwr", MEM_WB_RegWr_out, 0);
    check("rw_wrreg", MEM_WB_WrReg_out, 0);
    set_op(1'b0, 1'b0, 2'b01, 1'b1, 5'd6, 32'h300, '0, '0);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("late_req", mem_req, 1'b0);
    tick();
    check("late_data", MEM_WB_data_out, 0);
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 5'd8, 32'h104, '0, '0);
    mem_rdata = 32'h55;
    @(negedge clk);
    check("post_rst_stall", stall, 1'b0);
    tick();
    check("post_rst_data", MEM_WB_data_out, 32'h55);
    mem_ack = 1'b0; mem_rdata = '0;

    // Access that never acks
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 5'd7, 32'h400, '0, '0);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_stall", stall, 1'b1);
      tick();
    end
    @(negedge clk);
    check("to_stall_drop", stall, 1'b0);
    check("to_req", mem_req, 1'b0);
    tick();
    check("to_err", MEM_WB_err_out, 1);
    check("to_regwr", MEM_WB_RegWr_out, 0);
    check("to_wrreg", MEM_WB_WrReg_out, 7);
    check("to_data", MEM_WB_data_out, 0);
    nop();
    tick();
`else
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      check("hold_stall", stall, 1'b1);
      tick();
    end
    check("hold_regwr", MEM_WB_RegWr_out, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nop();
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
